flash_arbiter: RTL and testbench

Shares the single SPI flash read engine (`flash`, dual-IO, 16-bit word reads) between two requesters: port 0 (chipset/Kickstart ROM fetch) and port 1 (firmware/OSD loader). It converts a level request/ack handshake into the engine's `cs` rising-edge trigger and `busy` completion protocol. It serialises requests with port-0 priority plus anti-starvation, and optionally prefetches the next sequential port-0 word. It sits between the chipset/loader and the `flash` instance.

---
 rtl/flash_pkg.sv | 18 +
 rtl/flash_arbiter_if.sv | 29 ++
 rtl/flash_prefetch_buf.sv | 39 +++
 rtl/flash_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_flash_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_pkg.sv
// Shared types and widths for the flash arbiter and its prefetch buffer.
package flash_pkg;

    localparam int FLASH_AW = 22;
    localparam int FLASH_DW = 16;

    typedef logic [FLASH_AW-1:0] addr_t;
    typedef logic [FLASH_DW-1:0] data_t;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    typedef enum logic [1:0] {P0, P1, PF} owner_t;

    // Sequential word address; 22-bit arithmetic wraps 3FFFFF -> 000000.
    function automatic addr_t next_addr(input addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester ports plus flash engine side of the arbiter, bundled as one interface.
interface flash_arbiter_if;
    import flash_pkg::*;

    logic  p0_req;
    addr_t p0_addr;
    logic  p0_ack;
    data_t p0_data;
    logic  p1_req;
    addr_t p1_addr;
    logic  p1_ack;
    data_t p1_data;
    logic  flash_ready;
    logic  flash_busy;
    data_t flash_dout;
    addr_t flash_addr;
    logic  flash_cs;

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_addr, flash_ready, flash_busy, flash_dout,
        output p0_ack, p0_data, p1_ack, p1_data, flash_addr, flash_cs
    );

    modport master (
        output p0_req, p0_addr, p1_req, p1_addr, flash_ready, flash_busy, flash_dout,
        input  p0_ack, p0_data, p1_ack, p1_data, flash_addr, flash_cs
    );

endinterface

// File: rtl/flash_prefetch_buf.sv
// One-entry port-0 prefetch buffer: address/data/valid, hit compare, next address.
module flash_prefetch_buf
    import flash_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_load,
    input  addr_t i_load_addr,
    input  data_t i_load_data,
    input  logic  i_clear,
    input  addr_t i_cmp_addr,
    output logic  o_hit,
    output data_t o_data,
    output addr_t o_next_addr
);

    addr_t r_addr;
    data_t r_data;
    logic  r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_addr  <= i_load_addr;
            r_data  <= i_load_data;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit       = r_valid && (r_addr == i_cmp_addr);
    assign o_data      = r_data;
    assign o_next_addr = next_addr(r_addr);

endmodule

// File: rtl/flash_arbiter.sv
// Two-port arbiter in front of the SPI flash read engine (port-0 priority, anti-starvation).
// Define FLASH_ARB_PREFETCH_EN to add the sequential port-0 prefetch buffer.
module flash_arbiter
    import flash_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            reset,
    flash_arbiter_if.slave bus
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_CNT = CW'(STARVE_MAX);

    state_t        r_state;
    owner_t        r_owner;
    logic [CW-1:0] r_starve;
    logic          r_p0_ack;
    logic          r_p1_ack;
    data_t         r_p0_data;
    data_t         r_p1_data;
    addr_t         r_flash_addr;
    logic          r_flash_cs;

    logic          w_can_grant;
    logic          w_starved;
    logic [CW-1:0] w_starve_inc;
    logic          w_gnt_en;
    logic          w_gnt_hit;
    owner_t        w_gnt_owner;
    addr_t         w_gnt_addr;

    logic          w_pf_hit;
    data_t         w_pf_data;
    logic          w_pf_want;
    addr_t         w_pf_addr;
    logic          w_pf_match;

    assign w_can_grant  = bus.flash_ready && !bus.flash_busy;
    assign w_starved    = bus.p1_req && (r_starve == STARVE_CNT);
    assign w_starve_inc = (r_starve == STARVE_CNT) ? r_starve : r_starve + CW'(1);

`ifdef FLASH_ARB_PREFETCH_EN
    logic  r_pf_want;
    addr_t r_pf_addr;
    logic  w_buf_hit;
    addr_t w_buf_next;
    logic  w_pf_done;

    assign w_pf_done  = (r_state == DONE) && (r_owner == PF);
    assign w_pf_match = w_pf_done && bus.p0_req && (bus.p0_addr == r_flash_addr);
    assign w_pf_hit   = bus.p0_req && w_buf_hit;
    assign w_pf_want  = r_pf_want;
    assign w_pf_addr  = r_pf_addr;

    flash_prefetch_buf u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_pf_done && !w_pf_match),
        .i_load_addr (r_flash_addr),
        .i_load_data (bus.flash_dout),
        .i_clear     (w_gnt_hit),
        .i_cmp_addr  (bus.p0_addr),
        .o_hit       (w_buf_hit),
        .o_data      (w_pf_data),
        .o_next_addr (w_buf_next)
    );

    // Every word handed to port 0 (read, hit or in-flight match) arms a fetch of the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pf_want <= 1'b0;
            r_pf_addr <= '0;
        end else if ((r_state == DONE) && (r_owner == P0)) begin
            r_pf_want <= 1'b1;
            r_pf_addr <= next_addr(r_flash_addr);
        end else if (w_gnt_hit) begin
            r_pf_want <= 1'b1;
            r_pf_addr <= w_buf_next;
        end else if (w_pf_match) begin
            r_pf_want <= 1'b1;
            r_pf_addr <= next_addr(r_flash_addr);
        end else if (w_gnt_en && (w_gnt_owner == PF)) begin
            r_pf_want <= 1'b0;
        end
    end
`else
    assign w_pf_hit   = 1'b0;
    assign w_pf_data  = '0;
    assign w_pf_want  = 1'b0;
    assign w_pf_addr  = '0;
    assign w_pf_match = 1'b0;
`endif

    always_comb begin
        w_gnt_en    = 1'b0;
        w_gnt_hit   = 1'b0;
        w_gnt_owner = P0;
        w_gnt_addr  = bus.p0_addr;
        if ((r_state == IDLE) && w_can_grant) begin
            if (w_pf_hit) begin
                w_gnt_hit = 1'b1;
            end else if (w_starved) begin
                w_gnt_en    = 1'b1;
                w_gnt_owner = P1;
                w_gnt_addr  = bus.p1_addr;
            end else if (bus.p0_req) begin
                w_gnt_en = 1'b1;
            end else if (bus.p1_req) begin
                w_gnt_en    = 1'b1;
                w_gnt_owner = P1;
                w_gnt_addr  = bus.p1_addr;
            end else if (w_pf_want) begin
                w_gnt_en    = 1'b1;
                w_gnt_owner = PF;
                w_gnt_addr  = w_pf_addr;
            end
        end
    end

    // A request still high in its ack cycle counts as a fresh request in that same IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= P0;
            r_starve     <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_data    <= '0;
            r_p1_data    <= '0;
            r_flash_addr <= '0;
            r_flash_cs   <= 1'b0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_hit) begin
                        r_p0_ack  <= 1'b1;
                        r_p0_data <= w_pf_data;
                        if (bus.p1_req) r_starve <= w_starve_inc;
                    end else if (w_gnt_en) begin
                        r_owner      <= w_gnt_owner;
                        r_flash_addr <= w_gnt_addr;
                        r_flash_cs   <= 1'b1;
                        r_state      <= START;
                        if (w_gnt_owner == P1) begin
                            r_starve <= '0;
                        end else if ((w_gnt_owner == P0) && bus.p1_req) begin
                            r_starve <= w_starve_inc;
                        end
                    end
                end
                START: begin
                    if (bus.flash_busy) begin
                        r_flash_cs <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.flash_busy) r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    case (r_owner)
                        P0: begin
                            r_p0_ack  <= 1'b1;
                            r_p0_data <= bus.flash_dout;
                        end
                        P1: begin
                            r_p1_ack  <= 1'b1;
                            r_p1_data <= bus.flash_dout;
                        end
                        default: begin
                            if (w_pf_match) begin
                                r_p0_ack  <= 1'b1;
                                r_p0_data <= bus.flash_dout;
                                if (bus.p1_req) r_starve <= w_starve_inc;
                            end
                        end
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.p0_ack     = r_p0_ack;
    assign bus.p0_data    = r_p0_data;
    assign bus.p1_ack     = r_p1_ack;
    assign bus.p1_data    = r_p1_data;
    assign bus.flash_addr = r_flash_addr;
    assign bus.flash_cs   = r_flash_cs;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a behavioural flash engine model.
// Prefetch scenarios run only when FLASH_ARB_PREFETCH_EN is defined.
module tb_flash_arbiter;
    import flash_pkg::*;

    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flash_arbiter_if bus ();

    flash_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_t expQ0[$];
    data_t expQ1[$];
    addr_t stimQ0[$];
    addr_t stimQ1[$];

    // Flash content is a fixed function of the word address.
    function automatic data_t flashWord(input addr_t a);
        if (a == 22'h012345) return 16'hBEEF;
        return a[15:0] ^ {a[21:16], 10'h1A5};
    endfunction

    logic [2:0] csSync = '0;
    logic       mBusy  = 1'b0;
    int         mCnt   = 0;
    int         mLen   = 3;
    addr_t      mAddr  = '0;
    data_t      mDout  = '0;

    assign bus.flash_busy = mBusy;
    assign bus.flash_dout = mDout;

    // Engine model: two-flop cs synchroniser, edge detect, busy for mLen+1 cycles, never reset.
    always @(posedge clk) begin
        csSync <= {csSync[1:0], bus.flash_cs};
        if (!mBusy) begin
            if (csSync[1] && !csSync[2]) begin
                mBusy <= 1'b1;
                mAddr <= bus.flash_addr;
                mCnt  <= mLen;
            end
        end else if (mCnt == 0) begin
            mBusy <= 1'b0;
            mDout <= flashWord(mAddr);
        end else begin
            mCnt <= mCnt - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    int    ackSeq     = 0;
    int    p1AckSeq   = 0;
    int    p0AckCount = 0;
    int    csCount    = 0;
    addr_t lastCsAddr = '0;
    logic  prevCs     = 1'b0;
    logic  prevBusy   = 1'b0;

    // Monitor: pops the scoreboard on every ack and polices cs triggers.
    always @(posedge clk) begin
        #1;
        if (bus.p0_ack) begin
            ackSeq++;
            p0AckCount++;
            if (expQ0.size() == 0) checkOutput("p0_spurious_ack", 32'(bus.p0_data), 32'hFFFFFFFF);
            else                   checkOutput("p0_data", 32'(bus.p0_data), 32'(expQ0.pop_front()));
        end
        if (bus.p1_ack) begin
            ackSeq++;
            p1AckSeq = ackSeq;
            if (expQ1.size() == 0) checkOutput("p1_spurious_ack", 32'(bus.p1_data), 32'hFFFFFFFF);
            else                   checkOutput("p1_data", 32'(bus.p1_data), 32'(expQ1.pop_front()));
        end
        if (bus.flash_cs && !prevCs) begin
            checkOutput("cs_while_busy", 32'(prevBusy), 32'h0);
            csCount++;
            lastCsAddr = bus.flash_addr;
        end
        prevCs   = bus.flash_cs;
        prevBusy = bus.flash_busy;
    end

    // One cycle of requester behaviour; a request dropped on ack may be reissued at once.
    task automatic applyStimulus(input int gapPct);
        addr_t a;
        @(posedge clk);
        #2;
        if (bus.p0_req && bus.p0_ack) bus.p0_req = 1'b0;
        if (bus.p1_req && bus.p1_ack) bus.p1_req = 1'b0;
        if (!bus.p0_req && stimQ0.size() > 0 && int'($urandom_range(99)) >= gapPct) begin
            a = stimQ0.pop_front();
            bus.p0_addr = a;
            bus.p0_req  = 1'b1;
            expQ0.push_back(flashWord(a));
        end
        if (!bus.p1_req && stimQ1.size() > 0 && int'($urandom_range(99)) >= gapPct) begin
            a = stimQ1.pop_front();
            bus.p1_addr = a;
            bus.p1_req  = 1'b1;
            expQ1.push_back(flashWord(a));
        end
    endtask

    task automatic waitDrain(input int maxCycles, input int gapPct, input bit randLen);
        int n = 0;
        while ((stimQ0.size() + stimQ1.size() + expQ0.size() + expQ1.size()) != 0 && n < maxCycles) begin
            if (randLen) mLen = int'($urandom_range(1, 6));
            applyStimulus(gapPct);
            n++;
        end
        checkOutput("drain_in_time", 32'(n < maxCycles), 32'h1);
    endtask

    initial begin
        int    base;
        int    n;
        addr_t seqAddr;

        bus.p0_req      = 1'b0;
        bus.p0_addr     = '0;
        bus.p1_req      = 1'b0;
        bus.p1_addr     = '0;
        bus.flash_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs", 32'(bus.flash_cs), 32'h0);
        checkOutput("rst_addr", 32'(bus.flash_addr), 32'h0);
        checkOutput("rst_p0_ack", 32'(bus.p0_ack), 32'h0);
        checkOutput("rst_p1_ack", 32'(bus.p1_ack), 32'h0);
        checkOutput("rst_p0_data", 32'(bus.p0_data), 32'h0);
        checkOutput("rst_p1_data", 32'(bus.p1_data), 32'h0);
        #1 reset = 1'b0;

        // Init gating: nothing reaches the engine before ready
        base = csCount;
        stimQ1.push_back(22'h2ABCDE);
        repeat (50) applyStimulus(0);
        checkOutput("init_gate_no_cs", 32'(csCount - base), 32'h0);
        bus.flash_ready = 1'b1;
        waitDrain(200, 0, 1'b0);
        checkOutput("init_one_cs", 32'(csCount - base), 32'h1);

        // Basic port-0 read
        base = csCount;
        mLen = 4;
        stimQ0.push_back(22'h012345);
        waitDrain(200, 0, 1'b0);
        checkOutput("basic_addr", 32'(lastCsAddr), 32'h012345);
`ifndef FLASH_ARB_PREFETCH_EN
        repeat (5) applyStimulus(0);
        checkOutput("basic_cs_low", 32'(bus.flash_cs), 32'h0);
        checkOutput("basic_one_cs", 32'(csCount - base), 32'h1);
`endif
        repeat (20) applyStimulus(0);

        // Simultaneous requests with port 0 held continuously: port 1 is the 5th ack
        base = ackSeq;
        for (int i = 0; i < 6; i++) stimQ0.push_back(22'($urandom));
        stimQ1.push_back(22'($urandom));
        waitDrain(500, 0, 1'b0);
        checkOutput("starve_p1_position", 32'(p1AckSeq - base), 32'(STARVE_MAX + 1));

        // Randomised traffic, port-0 addresses often sequential
        seqAddr = 22'($urandom);
        for (int i = 0; i < 40; i++) begin
            seqAddr = ($urandom_range(1) == 1) ? next_addr(seqAddr) : 22'($urandom);
            stimQ0.push_back(seqAddr);
            stimQ1.push_back(22'($urandom));
        end
        waitDrain(6000, 60, 1'b1);
        repeat (20) applyStimulus(0);

        // Reset during WAIT while the engine stays busy
        mLen = 20;
        stimQ0.push_back(22'h155555);
        n = 0;
        while (!(mBusy && mCnt == 10) && n < 200) begin
            applyStimulus(0);
            n++;
        end
        checkOutput("reach_wait", 32'(n < 200), 32'h1);
        reset = 1'b1;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        stimQ0.delete();
        expQ0.delete();
        base = p0AckCount;
        @(posedge clk);
        #1;
        checkOutput("midrst_cs", 32'(bus.flash_cs), 32'h0);
        checkOutput("midrst_addr", 32'(bus.flash_addr), 32'h0);
        checkOutput("midrst_p0_ack", 32'(bus.p0_ack), 32'h0);
        checkOutput("midrst_p0_data", 32'(bus.p0_data), 32'h0);
        #1 reset = 1'b0;
        mLen = 3;
        n = csCount;
        stimQ1.push_back(22'h0F0F0F);
        waitDrain(300, 0, 1'b0);
        checkOutput("midrst_no_stale_ack", 32'(p0AckCount - base), 32'h0);
        checkOutput("midrst_one_cs", 32'(csCount - n), 32'h1);

`ifdef FLASH_ARB_PREFETCH_EN
        // Prefetch hit across the address wrap
        repeat (20) applyStimulus(0);
        stimQ0.push_back(22'h3FFFFF);
        waitDrain(200, 0, 1'b0);
        repeat (30) applyStimulus(0);
        checkOutput("pf_wrap_addr", 32'(lastCsAddr), 32'h0);
        base = csCount;
        stimQ0.push_back(22'h000000);
        n = 0;
        do begin
            applyStimulus(0);
            n++;
        end while (expQ0.size() != 0 && n < 10);
        checkOutput("pf_hit_latency_ok", 32'(n <= 2), 32'h1);
        checkOutput("pf_hit_no_cs", 32'(csCount - base), 32'h0);
        repeat (30) applyStimulus(0);
        checkOutput("pf_after_hit_addr", 32'(lastCsAddr), 32'h1);

        // Prefetch miss: a different address waits for the in-flight prefetch
        stimQ0.push_back(22'h000010);
        waitDrain(200, 0, 1'b0);
        base = csCount;
        n = 0;
        while (csCount == base && n < 20) begin
            applyStimulus(0);
            n++;
        end
        checkOutput("pf_miss_prefetch_addr", 32'(lastCsAddr), 32'h11);
        stimQ0.push_back(22'h000100);
        waitDrain(200, 0, 1'b0);
        checkOutput("pf_miss_issue_addr", 32'(lastCsAddr), 32'h100);
        checkOutput("pf_miss_cs_count", 32'(csCount - base), 32'h2);
`endif

        repeat (5) applyStimulus(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
